// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - single-outstanding Wishbone classic master with valid/ready command/response channels
module wb_cmd_master #(
    parameter int TIMEOUT = 256,
    parameter int TO_W    = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [4:0]  cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        rsp_tout,
    output logic [4:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_int_i,
    output logic        int_rise
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [1:0]      state;
    logic [TO_W-1:0] cnt;
    logic            int_q;
    logic            timeout_hit;

    // With TIMEOUT of zero the counter is free-running and never terminates a cycle.
    assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
            rsp_tout  <= 1'b0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_sel_o  <= '0;
            wb_we_o   <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        wb_adr_o  <= cmd_adr;
                        wb_dat_o  <= cmd_dat;
                        wb_sel_o  <= cmd_sel;
                        wb_we_o   <= cmd_we;
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= 1'b1;
                        cmd_ready <= 1'b0;
                        cnt       <= '0;
                        state     <= S_BUS;
                    end
                end
                S_BUS: begin
                    cnt <= cnt + 1'b1;
                    // err wins over a simultaneous ack
                    if (wb_stb_o && (wb_err_i || wb_ack_i || timeout_hit)) begin
                        rsp_err   <= wb_err_i;
                        rsp_tout  <= !wb_err_i && !wb_ack_i;
                        rsp_dat   <= (!wb_err_i && wb_ack_i && !wb_we_o) ? wb_dat_i : 32'h0;
                        rsp_valid <= 1'b1;
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_we_o   <= 1'b0;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_dat   <= '0;
                        rsp_err   <= 1'b0;
                        rsp_tout  <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    wb_cyc_o  <= 1'b0;
                    wb_stb_o  <= 1'b0;
                end
            endcase
        end
    end

    // Interrupt edge detect runs regardless of bus activity.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            int_q    <= 1'b0;
            int_rise <= 1'b0;
        end else begin
            int_q    <= wb_int_i;
            int_rise <= wb_int_i & ~int_q;
        end
    end

endmodule
